// File: rtl/ss_display_scanner.sv
// Two-digit seven-segment scanner: latches an AXIS frame and multiplexes it onto
// a shared segment bus with dead-time between digits and a minimum per-frame hold.
module ss_display_scanner #(
    parameter int REFRESH_CYCLES = 50000,
    parameter int BLANK_CYCLES   = 2,
    parameter int HOLD_CYCLES    = 1000000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [1:0][6:0] s_data,
    input  logic            blank,
    output logic [6:0]      seg,
    output logic [1:0]      an
);

    localparam int MAX_LEN = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int HOLD_W  = $clog2(HOLD_CYCLES + 2);
    localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

    localparam logic [CNT_W-1:0]  REFRESH_LAST = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  BLANK_LAST   = CNT_W'(HAS_BLANK ? BLANK_CYCLES - 1 : 0);
    localparam logic [HOLD_W-1:0] HOLD_MAX     = HOLD_W'(HOLD_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BLANK0,
        ST_DIG0,
        ST_BLANK1,
        ST_DIG1
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic [1:0][6:0]   frame_reg, frame_next;
    logic              s_ready_reg, s_ready_next;
    logic [6:0]        seg_reg;
    logic [1:0]        an_reg;
    logic              transfer;
    logic [1:0]        an_on;
    logic [6:0]        seg_on;

    assign transfer = s_valid && s_ready_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        hold_next  = hold_reg;
        frame_next = frame_reg;
        if (transfer) begin
            // A new frame always restarts the scan from the top and re-arms the hold.
            frame_next = s_data;
            state_next = HAS_BLANK ? ST_BLANK0 : ST_DIG0;
            cnt_next   = '0;
            hold_next  = '0;
        end else begin
            if (state_reg != ST_IDLE && hold_reg != HOLD_MAX) begin
                hold_next = hold_reg + 1'b1;
            end
            case (state_reg)
                ST_BLANK0: begin
                    if (cnt_reg == BLANK_LAST) begin
                        state_next = ST_DIG0;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                ST_DIG0: begin
                    if (cnt_reg == REFRESH_LAST) begin
                        state_next = HAS_BLANK ? ST_BLANK1 : ST_DIG1;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                ST_BLANK1: begin
                    if (cnt_reg == BLANK_LAST) begin
                        state_next = ST_DIG1;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                ST_DIG1: begin
                    if (cnt_reg == REFRESH_LAST) begin
                        state_next = HAS_BLANK ? ST_BLANK0 : ST_DIG0;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Ready rises HOLD_CYCLES edges after the transfer; always ready while idle.
    assign s_ready_next = (state_next == ST_IDLE) || (hold_next == HOLD_MAX);

    // Outputs are decoded from the next state so a phase is visible on the edge it begins.
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_digit
        assign an_on[gi] = !blank && (state_next == ((gi == 0) ? ST_DIG0 : ST_DIG1));
    end

    always_comb begin
        seg_on = '0;
        if (an_on[0]) begin
            seg_on = frame_next[0];
        end else if (an_on[1]) begin
            seg_on = frame_next[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            hold_reg    <= '0;
            frame_reg   <= '0;
            s_ready_reg <= 1'b0;
            seg_reg     <= {7{SEG_ACTIVE_LOW}};
            an_reg      <= {2{SEG_ACTIVE_LOW}};
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            hold_reg    <= hold_next;
            frame_reg   <= frame_next;
            s_ready_reg <= s_ready_next;
            seg_reg     <= seg_on ^ {7{SEG_ACTIVE_LOW}};
            an_reg      <= an_on ^ {2{SEG_ACTIVE_LOW}};
        end
    end

    assign s_ready = s_ready_reg;
    assign seg     = seg_reg;
    assign an      = an_reg;

endmodule

// File: tb/tb_ss_display_scanner.sv
// Bench for ss_display_scanner: two instances (with and without blank/hold), checked
// every cycle against a time-since-transfer model plus hand-computed literals.
module tb_ss_display_scanner;

    localparam int R_A = 4;
    localparam int B_A = 2;
    localparam int H_A = 20;
    localparam int R_B = 4;
    localparam int B_B = 0;
    localparam int H_B = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_a, valid_a, ready_a, blank_a;
    logic [1:0][6:0] data_a;
    logic [6:0]      seg_a;
    logic [1:0]      an_a;
    logic            rst_b, valid_b, ready_b, blank_b;
    logic [1:0][6:0] data_b;
    logic [6:0]      seg_b;
    logic [1:0]      an_b;

    ss_display_scanner #(
        .REFRESH_CYCLES(R_A), .BLANK_CYCLES(B_A), .HOLD_CYCLES(H_A), .SEG_ACTIVE_LOW(1'b1)
    ) u_dut_a (
        .clk(clk), .rst(rst_a), .s_valid(valid_a), .s_ready(ready_a),
        .s_data(data_a), .blank(blank_a), .seg(seg_a), .an(an_a)
    );

    ss_display_scanner #(
        .REFRESH_CYCLES(R_B), .BLANK_CYCLES(B_B), .HOLD_CYCLES(H_B), .SEG_ACTIVE_LOW(1'b1)
    ) u_dut_b (
        .clk(clk), .rst(rst_b), .s_valid(valid_b), .s_ready(ready_b),
        .s_data(data_b), .blank(blank_b), .seg(seg_b), .an(an_b)
    );

    int checks   = 0;
    int failures = 0;

    // Model state: whether a frame is shown, edges since its transfer, and the frame.
    bit              m_active[2];
    int              m_t[2];
    logic [1:0][6:0] m_frame[2];
    bit              m_blank[2];
    bit              m_ready[2];

    task automatic check(string name, logic [7:0] got, logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic model_update(int l, logic rst, logic v, logic [1:0][6:0] d, logic bl, int h);
        if (rst) begin
            m_active[l] = 1'b0;
            m_t[l]      = 0;
            m_frame[l]  = '0;
            m_blank[l]  = 1'b0;
            m_ready[l]  = 1'b0;
        end else begin
            if (v && m_ready[l]) begin
                m_active[l] = 1'b1;
                m_t[l]      = 0;
                m_frame[l]  = d;
                m_ready[l]  = (h == 0);
            end else if (m_active[l]) begin
                m_t[l]++;
                m_ready[l] = (m_t[l] >= h);
            end else begin
                m_ready[l] = 1'b1;
            end
            m_blank[l] = bl;
        end
    endtask

    function automatic void model_out(int l, int b, int r, output logic [6:0] s, output logic [1:0] a);
        int p;
        int dig;
        s   = 7'h7F;
        a   = 2'b11;
        dig = -1;
        if (m_active[l] && !m_blank[l]) begin
            p = m_t[l] % (2 * (b + r));
            if (p >= b && p < b + r) dig = 0;
            else if (p >= 2 * b + r) dig = 1;
            if (dig >= 0) begin
                s = ~m_frame[l][dig];
                a = ~(2'b01 << dig);
            end
        end
    endfunction

    task automatic step();
        logic [6:0] es;
        logic [1:0] ea;
        @(posedge clk);
        model_update(0, rst_a, valid_a, data_a, blank_a, H_A);
        model_update(1, rst_b, valid_b, data_b, blank_b, H_B);
        #1;
        model_out(0, B_A, R_A, es, ea);
        check("a_seg", 8'(seg_a), 8'(es));
        check("a_an", 8'(an_a), 8'(ea));
        check("a_ready", 8'(ready_a), 8'(m_ready[0]));
        model_out(1, B_B, R_B, es, ea);
        check("b_seg", 8'(seg_b), 8'(es));
        check("b_an", 8'(an_b), 8'(ea));
        check("b_ready", 8'(ready_b), 8'(m_ready[1]));
    endtask

    logic [1:0][6:0] fr_b[3];
    logic [6:0]      seg_b_lit[3];

    initial begin
        fr_b      = '{{7'h12, 7'h34}, {7'h56, 7'h78}, {7'h11, 7'h2A}};
        seg_b_lit = '{7'h4B, 7'h07, 7'h55};
        rst_a = 1'b1; valid_a = 1'b0; blank_a = 1'b0; data_a = '0;
        rst_b = 1'b1; valid_b = 1'b0; blank_b = 1'b0; data_b = '0;

        // Reset
        repeat (3) begin
            step();
            check("rst_an", 8'(an_a), 8'h03);
            check("rst_seg", 8'(seg_a), 8'h7F);
            check("rst_ready", 8'(ready_a), 8'h00);
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        step();
        check("ready_after_rst", 8'(ready_a), 8'h01);
        check("idle_an", 8'(an_a), 8'h03);

        // Scan pattern, three-plus periods; s_data wiggles without a transfer
        valid_a = 1'b1;
        data_a  = {7'h06, 7'h3F};
        step();
        check("scan_n_an", 8'(an_a), 8'h03);
        valid_a = 1'b0;
        data_a  = {7'h7F, 7'h7F};
        for (int k = 1; k <= 36; k++) begin
            step();
            if (k == 1)  check("scan_n1_an", 8'(an_a), 8'h03);
            if (k == 2)  begin check("scan_dig0_an", 8'(an_a), 8'h02); check("scan_dig0_seg", 8'(seg_a), 8'h40); end
            if (k == 5)  check("scan_dig0_end_an", 8'(an_a), 8'h02);
            if (k == 6)  check("scan_blank1_an", 8'(an_a), 8'h03);
            if (k == 8)  begin check("scan_dig1_an", 8'(an_a), 8'h01); check("scan_dig1_seg", 8'(seg_a), 8'h79); end
            if (k == 19) check("scan_hold_ready", 8'(ready_a), 8'h00);
            if (k == 20) check("scan_hold_done", 8'(ready_a), 8'h01);
            if (k == 26) begin check("scan_p3_dig0_an", 8'(an_a), 8'h02); check("scan_p3_dig0_seg", 8'(seg_a), 8'h40); end
            if (k == 34) begin check("scan_p3_dig1_an", 8'(an_a), 8'h01); check("scan_p3_dig1_seg", 8'(seg_a), 8'h79); end
        end

        // Backpressure: frame held valid right after another transfer
        valid_a = 1'b1;
        data_a  = {7'h11, 7'h22};
        step();
        data_a = {7'h5B, 7'h4F};
        for (int j = 1; j <= 21; j++) begin
            step();
            if (j == 1)  check("bp_ready_low", 8'(ready_a), 8'h00);
            if (j == 19) check("bp_ready_still_low", 8'(ready_a), 8'h00);
            if (j == 20) check("bp_ready_high", 8'(ready_a), 8'h01);
        end
        valid_a = 1'b0;
        check("bp_xfer_dark", 8'(an_a), 8'h03);
        check("bp_xfer_ready", 8'(ready_a), 8'h00);
        step();
        step();
        check("bp_dig0_an", 8'(an_a), 8'h02);
        check("bp_dig0_seg", 8'(seg_a), 8'h30);

        // Blank override for 5 cycles in DIG0, release lands in DIG1
        blank_a = 1'b1;
        for (int j = 0; j < 5; j++) begin
            step();
            check("blank_an", 8'(an_a), 8'h03);
            check("blank_seg", 8'(seg_a), 8'h7F);
        end
        blank_a = 1'b0;
        step();
        check("unblank_an", 8'(an_a), 8'h01);
        check("unblank_seg", 8'(seg_a), 8'h24);
        step();

        // Reset during DIG1
        rst_a = 1'b1;
        step();
        check("midrst_an", 8'(an_a), 8'h03);
        check("midrst_seg", 8'(seg_a), 8'h7F);
        check("midrst_ready", 8'(ready_a), 8'h00);
        rst_a = 1'b0;
        step();
        check("midrst_ready_back", 8'(ready_a), 8'h01);
        repeat (6) begin
            step();
            check("midrst_dark", 8'(an_a), 8'h03);
        end

        // No hold, no blank: three back-to-back transfers
        valid_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_b = fr_b[i];
            step();
            check("b2b_ready", 8'(ready_b), 8'h01);
            check("b2b_an", 8'(an_b), 8'h02);
            check("b2b_seg", 8'(seg_b), 8'(seg_b_lit[i]));
        end
        valid_b = 1'b0;
        repeat (4) step();
        check("b2b_dig1_an", 8'(an_b), 8'h01);
        check("b2b_dig1_seg", 8'(seg_b), 8'h6E);
        repeat (8) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
